branch_predictor_bimodal: RTL
=============================

// Module: branch_predictor_bimodal
//
// PURPOSE
// - Responder side of the branch-decoded handshake: decode drives valid/is_jump/target;
//   this block returns prediction and target_post_predict in the same cycle.
// - Learns from the ALU branch_result (valid/prediction/outcome) through a table of
//   2-bit saturating counters indexed by PC bits.
// - Keeps branch and mispredict statistics for performance measurement.
// - Sits beside the hazard controller, between the decode and ALU stages.
//
// PARAMETERS
// - INDEX_BITS        default 7   log2 of table entries (128 counters)
// - FALLTHROUGH_BYTES default 8   not-taken next PC offset from dec_pc (branch + delay slot)
// - STAT_WIDTH        default 32  width of each statistics counter
//
// PORTS
// - clk                      in   1           core clock
// - rst_n                    in   1           asynchronous active-low reset
// - dec_pc                   in   ADDR_WIDTH  PC of the instruction in decode
// - dec_valid                in   1           decode instruction is a branch or jump
// - dec_is_jump              in   1           decode instruction is an unconditional jump
// - dec_target               in   ADDR_WIDTH  decoded taken target
// - dec_prediction           out  BranchOutcome  prediction returned to decode
// - dec_target_post_predict  out  ADDR_WIDTH  next PC implied by the prediction
// - ex_pc                    in   ADDR_WIDTH  PC of the branch resolved in the ALU
// - ex_valid                 in   1           branch result valid this cycle
// - ex_prediction            in   BranchOutcome  prediction carried with the branch
// - ex_outcome               in   BranchOutcome  actual resolved outcome
// - stat_branches            out  STAT_WIDTH  resolved branches counted
// - stat_mispredicts         out  STAT_WIDTH  resolved branches with prediction != outcome
//
// BEHAVIOUR
// - Index: idx = pc[INDEX_BITS+1:2], for both dec_pc and ex_pc. Aliasing is allowed.
// - Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. MSB = TAKEN.
// - Reset (async, rst_n low): every counter = 01; stat_* = 0.
//   Reset mid-update discards that update.
// - Lookup is combinational with zero latency:
//   - dec_is_jump = 1 -> TAKEN, target_post_predict = dec_target.
//   - Otherwise prediction = MSB of the counter.
//   - TAKEN -> target_post_predict = dec_target.
//   - NOT_TAKEN -> target_post_predict = dec_pc + FALLTHROUGH_BYTES. Add mod 2^ADDR_WIDTH.
//   - dec_valid = 0 -> same combinational values; the consumer ignores them.
//   - Lookup never modifies state.
// - Update at the posedge where ex_valid = 1:
//   - TAKEN -> counter+1, saturating at 11.
//   - NOT_TAKEN -> counter-1, saturating at 00.
//   - No update when ex_valid = 0.
// - Same-cycle lookup and update on the same idx: forward the post-update counter value
//   to dec_prediction (write-first).
// - Statistics, on an ex_valid edge:
//   - stat_branches+1.
//   - stat_mispredicts+1 if ex_prediction != ex_outcome.
//   - Both saturate at all-ones and never wrap.
// - ex_prediction is used only for statistics. It is not checked against the table.
// - All outputs are X-free after reset. No backpressure: the ALU drives at most one
//   result per cycle.
//
// STRUCTURE
// - mips_core_pkg: BranchOutcome (existing). Add typedef logic [1:0] BhtCounter and
//   constants BHT_WEAK_NT = 2'b01, BHT_STRONG_T = 2'b11.
// - ADDR_WIDTH comes from mips_core.svh.
// - One sub-module, sat_counter2: next-state = f(current, taken); purely combinational.
//   It is reused by the update path and the forwarding path.
// - Flop array of 2^INDEX_BITS BhtCounter with async reset. Single write port, one
//   combinational read port.
// - Top wrapper binds branch_decoded_ifc.hazard and branch_result_ifc to these ports.
//
// TESTING
// - Reset, dec_pc=0x400, dec_valid=1, not jump, target=0x500
//   -> NOT_TAKEN, tpp=0x408; stats 0/0.
// - Two ex updates pc=0x400 TAKEN (pred NT)
//   -> lookup 0x400 gives TAKEN, tpp=0x500; stat_branches=2, stat_mispredicts=2.
// - Five TAKEN then one NOT_TAKEN at 0x400 -> still TAKEN; two more NOT_TAKEN -> NOT_TAKEN.
//   Counter never wraps.
// - Forwarding: counter 01 at 0x600; same cycle ex TAKEN @0x600 and dec lookup 0x600
//   -> TAKEN that cycle.
// - Alias/jump: train 0x400 to 11, lookup 0x400+4*128 -> TAKEN.
//   dec_is_jump=1 on an untrained entry -> TAKEN, tpp=dec_target.
// - STAT_WIDTH=4: 20 mispredicted results -> both stats hold 15.
//   Assert rst_n mid-stream -> counters 01, stats 0 immediately, without a clock.

Source files
------------

// File: rtl/branch_predictor_bimodal_pkg.sv
// Shared types and constants for the bimodal branch predictor.
// Latency: n/a (types only).
// Backpressure: n/a.
package branch_predictor_bimodal_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    // 2-bit saturating counter; the MSB is the taken prediction
    typedef logic [1:0] BhtCounter;

    localparam BhtCounter BHT_STRONG_NT = 2'b00;
    localparam BhtCounter BHT_WEAK_NT   = 2'b01;
    localparam BhtCounter BHT_STRONG_T  = 2'b11;

endpackage

// File: rtl/branch_predictor_bimodal_sat_counter2.sv
// Next-state function of a 2-bit saturating counter: step towards the outcome.
// Latency: purely combinational.
// Backpressure: none.
module sat_counter2
    import branch_predictor_bimodal_pkg::*;
(
    input  BhtCounter cur,
    input  logic      taken,
    output BhtCounter nxt
);

    // Increment on taken, decrement on not-taken, hold at either end
    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != BHT_STRONG_T) begin
                nxt = BhtCounter'(cur + 2'd1);
            end
        end else begin
            if (cur != BHT_STRONG_NT) begin
                nxt = BhtCounter'(cur - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor_bimodal.sv
// Bimodal branch predictor: PC-indexed 2-bit counters, trained by resolved branches.
// Latency: lookup is zero-cycle combinational; training lands at the ex_valid edge.
// Backpressure: none; at most one lookup and one training result per cycle.
module branch_predictor_bimodal
    import branch_predictor_bimodal_pkg::*;
#(
    parameter int INDEX_BITS        = 7,
    parameter int FALLTHROUGH_BYTES = 8,
    parameter int STAT_WIDTH        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] dec_pc,
    input  logic                  dec_valid,
    input  logic                  dec_is_jump,
    input  logic [ADDR_WIDTH-1:0] dec_target,
    output BranchOutcome          dec_prediction,
    output logic [ADDR_WIDTH-1:0] dec_target_post_predict,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic                  ex_valid,
    input  BranchOutcome          ex_prediction,
    input  BranchOutcome          ex_outcome,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    BhtCounter              table_q [ENTRIES];
    logic [INDEX_BITS-1:0]  dec_idx;
    logic [INDEX_BITS-1:0]  ex_idx;
    BhtCounter              ex_cur;
    BhtCounter              ex_next;
    BhtCounter              dec_cnt;
    logic                   dec_taken;

    // Word-aligned PCs: bits [1:0] carry no information, upper bits alias freely.
    // dec_valid only qualifies the outputs for the consumer.
    logic unused_ok;
    assign unused_ok = ^{dec_valid, dec_pc[ADDR_WIDTH-1:INDEX_BITS+2], dec_pc[1:0],
                         ex_pc[ADDR_WIDTH-1:INDEX_BITS+2], ex_pc[1:0]};

    assign dec_idx = dec_pc[INDEX_BITS+1:2];
    assign ex_idx  = ex_pc[INDEX_BITS+1:2];
    assign ex_cur  = table_q[ex_idx];

    // One next-state instance serves both the table write and the write-first bypass
    sat_counter2 u_sat (
        .cur   (ex_cur),
        .taken (ex_outcome == TAKEN),
        .nxt   (ex_next)
    );

    // Counter table: single write port from the ALU result, reset to weakly not-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= BHT_WEAK_NT;
            end
        end else if (ex_valid) begin
            table_q[ex_idx] <= ex_next;
        end
    end

    // Lookup with write-first bypass; jumps are always taken
    always_comb begin
        dec_cnt = table_q[dec_idx];
        if (ex_valid && (ex_idx == dec_idx)) begin
            dec_cnt = ex_next;
        end
        dec_taken               = dec_is_jump | dec_cnt[1];
        dec_prediction          = dec_taken ? TAKEN : NOT_TAKEN;
        dec_target_post_predict = dec_taken ? dec_target
                                            : dec_pc + ADDR_WIDTH'(FALLTHROUGH_BYTES);
    end

    // Saturating performance counters, one step per resolved branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (ex_valid) begin
            if (stat_branches != '1) begin
                stat_branches <= stat_branches + 1'b1;
            end
            if ((ex_prediction != ex_outcome) && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 1'b1;
            end
        end
    end

endmodule
